// File: rtl/dff_share_arbiter.sv
// Round-robin arbiter sharing one WIDTH-bit register among NREQ requesters,
// with optional bounded grant locking.
module dff_share_arbiter #(
   parameter int unsigned NREQ     = 4,
   parameter int unsigned WIDTH    = 8,
   parameter int unsigned MAX_HOLD = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [NREQ-1:0]          req,
   input  logic [NREQ-1:0]          lock,
   input  logic [NREQ*WIDTH-1:0]    d_in,
   output logic [NREQ-1:0]          gnt,
   output logic [WIDTH-1:0]         q,
   output logic                     q_valid,
   output logic [$clog2(NREQ)-1:0]  q_owner,
   output logic                     busy
);

   localparam int unsigned OwnW  = $clog2(NREQ);
   localparam int unsigned HoldW = $clog2(MAX_HOLD + 1);

   logic [NREQ-1:0]  gnt_q, gnt_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic             valid_q, valid_d;
   logic [OwnW-1:0]  owner_q, owner_d;
   logic [OwnW-1:0]  ptr_q, ptr_d;
   logic [HoldW-1:0] hold_q, hold_d;

   logic             cur_busy;
   logic [NREQ-1:0]  others;
   logic             retain;
   logic             rr_found;
   logic [OwnW-1:0]  rr_win;
   logic [OwnW-1:0]  cand;
   logic             grant;
   logic [OwnW-1:0]  win;
   int               idx;

   always_comb begin
      cur_busy        = |gnt_q;
      others          = req;
      others[owner_q] = 1'b0;
      retain = cur_busy && req[owner_q] && lock[owner_q] &&
               ((hold_q < HoldW'(MAX_HOLD)) || (others == '0));

      // Pointer always sits at owner+1 after a grant, so forced rotation
      // falls out of the ordinary search once retain is refused.
      rr_found = 1'b0;
      rr_win   = '0;
      cand     = '0;
      idx      = 0;
      for (int i = 0; i < int'(NREQ); i++) begin
         idx = int'(ptr_q) + i;
         if (idx >= int'(NREQ)) idx = idx - int'(NREQ);
         cand = OwnW'(idx);
         if (!rr_found && req[cand]) begin
            rr_found = 1'b1;
            rr_win   = cand;
         end
      end

      grant = retain || rr_found;
      win   = retain ? owner_q : rr_win;

      gnt_d   = '0;
      q_d     = q_q;
      valid_d = 1'b0;
      owner_d = owner_q;
      ptr_d   = ptr_q;
      hold_d  = '0;
      if (grant) begin
         gnt_d[win] = 1'b1;
         q_d        = d_in[int'(win)*WIDTH +: WIDTH];
         valid_d    = 1'b1;
         owner_d    = win;
         ptr_d      = (win == OwnW'(NREQ - 1)) ? '0 : win + 1'b1;
         if (cur_busy && (win == owner_q)) begin
            hold_d = (hold_q == HoldW'(MAX_HOLD)) ? hold_q : hold_q + 1'b1;
         end else begin
            hold_d = HoldW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         gnt_q   <= '0;
         q_q     <= '0;
         valid_q <= 1'b0;
         owner_q <= '0;
         ptr_q   <= '0;
         hold_q  <= '0;
      end else begin
         gnt_q   <= gnt_d;
         q_q     <= q_d;
         valid_q <= valid_d;
         owner_q <= owner_d;
         ptr_q   <= ptr_d;
         hold_q  <= hold_d;
      end
   end

   assign gnt     = gnt_q;
   assign q       = q_q;
   assign q_valid = valid_q;
   assign q_owner = owner_q;
   assign busy    = |gnt_q;

   a_gnt_onehot0: assert property (@(posedge clk) disable iff (!rst) $onehot0(gnt_q));

endmodule

// File: tb/tb_dff_share_arbiter.sv
// Scoreboard bench for dff_share_arbiter: stimulus pushes expected outputs,
// a negedge monitor pops and compares them.
module tb_dff_share_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [3:0]  req = '0;
   logic [3:0]  lock = '0;
   logic [31:0] d_in = '0;
   logic [3:0]  gnt;
   logic [7:0]  q;
   logic        q_valid;
   logic [1:0]  q_owner;
   logic        busy;

   dff_share_arbiter #(.NREQ(4), .WIDTH(8), .MAX_HOLD(4)) dut (
      .clk     (clk),
      .rst     (rst),
      .req     (req),
      .lock    (lock),
      .d_in    (d_in),
      .gnt     (gnt),
      .q       (q),
      .q_valid (q_valid),
      .q_owner (q_owner),
      .busy    (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      int unsigned edge_no;
      logic [3:0]  gnt;
      logic [7:0]  q;
      logic        v;
      logic [1:0]  own;
      string       name;
   } exp_t;

   exp_t        sb[$];
   exp_t        e;
   int unsigned edge_cnt = 0;
   int          n_tests = 0;
   int          n_fail = 0;

   always @(posedge clk) edge_cnt <= edge_cnt + 1;

   always @(negedge clk) begin
      while (sb.size() > 0 && sb[0].edge_no <= edge_cnt) begin
         e = sb.pop_front();
         n_tests++;
         if (gnt !== e.gnt || q !== e.q || q_valid !== e.v || q_owner !== e.own ||
             busy !== (|e.gnt)) begin
            n_fail++;
            $display("FAIL %s: got gnt=%b q=%h v=%b own=%0d busy=%b, want gnt=%b q=%h v=%b own=%0d busy=%b",
                     e.name, gnt, q, q_valid, q_owner, busy, e.gnt, e.q, e.v, e.own, |e.gnt);
         end
      end
   end

   task automatic push(input string nm, input logic [3:0] eg, input logic [7:0] eq,
                       input logic ev, input logic [1:0] eo);
      exp_t x;
      x.edge_no = edge_cnt + 1;
      x.gnt = eg; x.q = eq; x.v = ev; x.own = eo; x.name = nm;
      sb.push_back(x);
   endtask

   // Called just after a posedge; inputs are sampled at the following edge.
   task automatic step(input string nm, input logic [3:0] r, input logic [3:0] l,
                       input logic [31:0] din, input logic [3:0] eg, input logic [7:0] eq,
                       input logic ev, input logic [1:0] eo);
      req = r; lock = l; d_in = din;
      push(nm, eg, eq, ev, eo);
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input string nm);
      @(negedge clk);
      #1 rst = 1'b0;
      req = '0; lock = '0;
      #1;
      n_tests++;
      if (gnt !== 4'b0 || q !== 8'h00 || q_valid !== 1'b0 || q_owner !== 2'd0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL %s: got gnt=%b q=%h v=%b own=%0d busy=%b, want all zero",
                  nm, gnt, q, q_valid, q_owner, busy);
      end
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      push({nm, "_idle"}, 4'b0000, 8'h00, 1'b0, 2'd0);
      @(posedge clk);
      #1;
   endtask

   localparam logic [31:0] DinAll = 32'h44332211;

   initial begin
      // Async reset mid-grant, then restart from pointer 0.
      do_reset("rst0");
      step("pre_rst_gnt", 4'b0010, 4'b0000, DinAll, 4'b0010, 8'h22, 1'b1, 2'd1);
      do_reset("rst_midgrant");
      step("post_rst_first", 4'b1111, 4'b0000, DinAll, 4'b0001, 8'h11, 1'b1, 2'd0);

      // Single requester re-granted each cycle, q holds once idle.
      do_reset("rst_single");
      for (int i = 0; i < 3; i++)
         step("single", 4'b0001, 4'b0000, 32'h000000A5, 4'b0001, 8'hA5, 1'b1, 2'd0);
      step("single_idle", 4'b0000, 4'b0000, 32'h000000FF, 4'b0000, 8'hA5, 1'b0, 2'd0);
      step("single_idle2", 4'b0000, 4'b0000, 32'h000000FF, 4'b0000, 8'hA5, 1'b0, 2'd0);

      // Full contention rotates 0,1,2,3,...
      do_reset("rst_rr");
      for (int i = 0; i < 8; i++) begin
         logic [3:0] g;
         logic [1:0] w;
         w = 2'(i % 4);
         g = 4'b0001 << w;
         step("rr", 4'b1111, 4'b0000, DinAll, g, 8'(8'h11 * (w + 1)), 1'b1, w);
      end

      // Lock with contention: 4 grants, forced rotation, 4 grants again.
      do_reset("rst_lock");
      for (int i = 0; i < 4; i++)
         step("lock_a", 4'b0011, 4'b0001, 32'h0000BBAA, 4'b0001, 8'hAA, 1'b1, 2'd0);
      step("lock_rot", 4'b0011, 4'b0001, 32'h0000BBAA, 4'b0010, 8'hBB, 1'b1, 2'd1);
      for (int i = 0; i < 4; i++)
         step("lock_b", 4'b0011, 4'b0001, 32'h0000BBAA, 4'b0001, 8'hAA, 1'b1, 2'd0);

      // Lock with no contention, then a newcomer takes over at saturation.
      do_reset("rst_solo");
      for (int i = 0; i < 10; i++)
         step("solo_lock", 4'b0001, 4'b0001, 32'h00C3005C, 4'b0001, 8'h5C, 1'b1, 2'd0);
      step("solo_yield", 4'b0101, 4'b0001, 32'h00C3005C, 4'b0100, 8'hC3, 1'b1, 2'd2);

      // Owner 3 drops req mid-hold; search wraps to requester 0.
      do_reset("rst_drop");
      step("drop_g0", 4'b1001, 4'b1000, 32'h08000001, 4'b0001, 8'h01, 1'b1, 2'd0);
      step("drop_g3", 4'b1001, 4'b1000, 32'h08000001, 4'b1000, 8'h08, 1'b1, 2'd3);
      step("drop_hold", 4'b1001, 4'b1000, 32'h08000001, 4'b1000, 8'h08, 1'b1, 2'd3);
      step("drop_wrap", 4'b0001, 4'b1000, 32'h08000001, 4'b0001, 8'h01, 1'b1, 2'd0);
      step("drop_idle", 4'b0000, 4'b0000, 32'h08000001, 4'b0000, 8'h01, 1'b0, 2'd0);

      for (int i = 0; i < 5 && sb.size() > 0; i++) @(posedge clk);
      while (sb.size() > 0) begin
         e = sb.pop_front();
         n_tests++;
         n_fail++;
         $display("FAIL %s: got no compare, want compare at edge %0d", e.name, e.edge_no);
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/dff_share_arbiter.md
Name: dff_share_arbiter

Overview:
- Round-robin arbiter that shares one WIDTH-bit D-flip-flop register between NREQ requesters.
- Each cycle it picks at most one requester and loads that requester's data into the shared register.
- It reports the owner and a valid strobe alongside the loaded data.
- Sits between requester agents and the shared D-register datapath, sequencing all loads into it.

Parameters:
- NREQ, 4, number of requesters (>=2).
- WIDTH, 8, width of the shared register and of each requester's data.
- MAX_HOLD, 4, maximum consecutive grants a locking requester keeps while others are waiting (>=1).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-low; asserted when 0.
- req  input  NREQ  per-requester request; bit i belongs to requester i.
- lock  input  NREQ  per-requester hold-grant request; only meaningful together with req[i].
- d_in  input  NREQ*WIDTH  requester data; requester i uses bits [i*WIDTH +: WIDTH].
- gnt  output  NREQ  registered one-hot grant, or all-zero.
- q  output  WIDTH  shared register contents.
- q_valid  output  1  high in any cycle where q was loaded at the preceding edge.
- q_owner  output  $clog2(NREQ)  index of the requester whose data is in q.
- busy  output  1  equals |gnt.

Behaviour:
- Reset (rst=0, asynchronous, immediate, independent of clk):
  - gnt=0, q=0, q_valid=0, q_owner=0, busy=0, hold_cnt=0.
  - RR pointer=0, so requester 0 has top priority first.
  - Reset asserted mid-grant clears everything at once. No grant resumes after release; arbitration restarts from pointer 0.
- Latency: req/lock/d_in sampled at edge N; gnt, q, q_valid, q_owner valid after edge N (one cycle).
- Winner selection at each edge, with cur = current owner (gnt!=0):
  - Retain: cur keeps the grant if req[cur] & lock[cur], AND either hold_cnt < MAX_HOLD or no other req bit is set.
  - Otherwise round-robin: search req starting at pointer, upward with wrap-around from NREQ-1 to 0. The first set bit wins.
  - No req bits set: gnt<=0, q_valid<=0, q and q_owner hold, hold_cnt<=0.
- On a grant to winner w:
  - gnt<=onehot(w), q<=d_in[w], q_owner<=w, q_valid<=1.
  - pointer<=(w+1) mod NREQ.
- hold_cnt:
  - Set to 1 when w differs from the previous owner, or when the previous cycle had no grant.
  - Incremented, saturating at MAX_HOLD, when the same owner is granted in consecutive cycles.
- Without lock, each grant lasts one cycle, then re-arbitration runs from w+1. A sole requester is therefore re-granted every cycle.
- Owner drops req mid-hold: at the next edge it loses the grant; the normal RR search starts from the pointer.
- lock without req is ignored. lock on a non-owner has no effect until that requester wins.
- Forced rotation: after MAX_HOLD consecutive grants with others waiting, the search starts from owner+1. The owner cannot win that edge unless it is the only requester.
- q is written only on grant edges; it never changes while gnt=0.
- At most one gnt bit is high in any cycle (must be checked by assertion).
- Structure: single always_ff for state (gnt, q, q_owner, q_valid, pointer, hold_cnt) plus combinational next-winner logic. No combinational path from inputs to outputs.

Test Plan:
- Async reset: rst=0 applied mid-cycle while gnt=0010 -> gnt=0, q=0x00, q_valid=0, q_owner=0 immediately, without waiting for a clk edge. After release with req=1111, the first gnt is 0001.
- Single request: req=0001, d_in[0]=0xA5 held 3 cycles -> gnt=0001, q=0xA5, q_valid=1, q_owner=0 each cycle. With req=0 -> gnt=0, q_valid=0, q stays 0xA5.
- Full contention, no lock: req=1111, d_in=0x11/0x22/0x33/0x44 for 8 cycles -> gnt sequence 0001,0010,0100,1000,0001,..., with q 0x11,0x22,0x33,0x44 repeating.
- Lock with contention: req=0011, lock=0001 -> gnt=0001 for exactly 4 cycles, then 0010 for 1 cycle, then 0001 for 4 cycles (hold_cnt restarts at 1).
- Lock without contention: req=0001, lock=0001 for 10 cycles -> gnt=0001 all 10 cycles. Then raise req[2] -> gnt=0100 on the next edge, since hold_cnt is already saturated.
- Owner drop and wrap: req=1001, lock=1000, with owner=3 at hold_cnt=2, then req[3] drops -> next gnt=0001 (wrap from pointer 0). With req=0 afterwards -> busy=0 and q_owner=0 holds.
